sha256_share_arbiter: RTL and testbench

Round-robin arbiter that shares one SHA-256 accelerator pipeline (padder → manager → core) among NUM_REQ independent message streams. It locks the engine to one requester from the first beat of a message until that requester accepts the digest. It then rotates priority. It sits between the per-requester FIFO controllers and the single SHA-256 top wrapper inside the tile's accelerator unit.

---
 rtl/sha256_share_arbiter.sv | 124 ++++++++++++
 tb/tb_sha256_share_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_share_arbiter.sv
// Round-robin arbiter sharing one SHA-256 engine across NUM_REQ message streams.
// The grant is held from the first beat until the owner accepts its digest, then priority rotates.
module sha256_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 64,
  parameter int DIGEST_W = 256,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           eng_valid,
  output logic [DATA_W-1:0]              eng_data,
  output logic                           eng_last,
  input  logic                           eng_ready,
  input  logic                           eng_digest_valid,
  input  logic [DIGEST_W-1:0]            eng_digest,
  output logic                           eng_digest_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DIGEST_W-1:0]            rsp_digest,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic                           busy,
  output logic [IDX_W-1:0]               owner,
  output logic [31:0]                    done_cnt
);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DIG, RESP} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick;
  logic [31:0]         done_cnt_q, done_cnt_d;
  logic [DIGEST_W-1:0] dig_q, dig_d;
  logic [NUM_REQ-1:0]  own_oh;
  logic                any_req;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    int j;
    j       = 0;
    pick    = rr_ptr_q;
    any_req = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid[j]) begin
        pick    = IDX_W'(j);
        any_req = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign own_oh[g] = (owner_q == IDX_W'(g));
  end

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    owner_d          = owner_q;
    done_cnt_d       = done_cnt_q;
    dig_d            = dig_q;
    req_ready        = '0;
    eng_valid        = 1'b0;
    eng_data         = '0;
    eng_last         = 1'b0;
    eng_digest_ready = 1'b0;
    rsp_valid        = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = pick;
          state_d = STREAM;
        end
      end
      STREAM: begin
        eng_valid = req_valid[owner_q];
        eng_data  = req_data[owner_q];
        eng_last  = req_last[owner_q];
        req_ready = own_oh & {NUM_REQ{eng_ready}};
        if (eng_valid && eng_ready && eng_last) state_d = WAIT_DIG;
      end
      WAIT_DIG: begin
        // Digests offered in any other state stay parked in the engine.
        eng_digest_ready = 1'b1;
        if (eng_digest_valid) begin
          dig_d   = eng_digest;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = own_oh;
        if (rsp_ready[owner_q]) begin
          state_d    = IDLE;
          rr_ptr_d   = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
          done_cnt_d = done_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      done_cnt_q <= '0;
      dig_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      done_cnt_q <= done_cnt_d;
      dig_q      <= dig_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign owner      = owner_q;
  assign done_cnt   = done_cnt_q;
  assign rsp_digest = dig_q;
endmodule

// File: tb/tb_sha256_share_arbiter.sv
// Bench for sha256_share_arbiter: directed vector table, hand sequences for reset and
// rotation gap, and random traffic against a message-level reference model.
module tb_sha256_share_arbiter;
  localparam int N = 4, DW = 64, GW = 256, IW = 2;
  localparam logic [GW-1:0] D1 = {4{64'hA5A5_0000_1234_5678}};
  localparam logic [DW-1:0] DEAD = 64'hDEAD_BEEF_0000_0002;
  typedef logic [GW-1:0] w_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req_valid, req_last, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][DW-1:0] req_data;
  logic                eng_valid, eng_last, eng_ready, eng_digest_valid, eng_digest_ready, busy;
  logic [DW-1:0]       eng_data;
  logic [GW-1:0]       eng_digest, rsp_digest;
  logic [IW-1:0]       owner;
  logic [31:0]         done_cnt;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  sha256_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DIGEST_W(GW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .eng_valid(eng_valid), .eng_data(eng_data), .eng_last(eng_last), .eng_ready(eng_ready),
    .eng_digest_valid(eng_digest_valid), .eng_digest(eng_digest), .eng_digest_ready(eng_digest_ready),
    .rsp_valid(rsp_valid), .rsp_digest(rsp_digest), .rsp_ready(rsp_ready),
    .busy(busy), .owner(owner), .done_cnt(done_cnt));

  task automatic chk(input string nm, input w_t act, input w_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid = '0; req_last = '0; req_data = '0; eng_ready = 1'b0;
    eng_digest_valid = 1'b0; eng_digest = '0; rsp_ready = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed table: single 4-beat message from req0 with bubbles while req2 waits.
  typedef struct {
    logic [N-1:0] rv, rl; logic [DW-1:0] d0; logic erdy, edv; logic [N-1:0] rspr;
    logic [N-1:0] x_rr; logic x_ev; logic [DW-1:0] x_ed; logic x_el, x_edr;
    logic [N-1:0] x_rspv; logic x_busy; logic [IW-1:0] x_own; logic [31:0] x_done; logic x_dsel;
  } vec_t;
  vec_t tbl[15];

  // Reference model state (message level) and per-requester message queues.
  logic [DW-1:0] qd [N][256];
  logic          ql [N][256];
  int            qh [N], qt [N];
  int            m_ph, m_rr, m_own;
  logic [31:0]   m_done;
  logic [GW-1:0] m_dig;

  task automatic model_init();
    m_ph = 0; m_rr = 0; m_own = 0; m_done = '0; m_dig = '0;
    for (int r = 0; r < N; r++) begin qh[r] = 0; qt[r] = 0; end
  endtask

  task automatic run_rand(input int cycles, input logic [N-1:0] act, input int max_len,
                          input int fillp, input int vprob, input int rprob, input int dprob);
    logic [N-1:0] x_rr, x_rspv;
    logic         x_ev;
    int           k;
    for (int c = 0; c < cycles; c++) begin
      for (int r = 0; r < N; r++) begin
        if (qh[r] == qt[r] && act[r] && $urandom_range(0, 99) < fillp) begin
          int len = $urandom_range(1, max_len);
          for (int b = 0; b < len; b++) begin
            qd[r][qt[r]%256] = {8'(r), 24'(qt[r]), 32'($urandom)};
            ql[r][qt[r]%256] = (b == len-1);
            qt[r]++;
          end
        end
        req_valid[r] = (qh[r] != qt[r]) && ($urandom_range(0, 99) < vprob);
        req_data[r]  = (qh[r] != qt[r]) ? qd[r][qh[r]%256] : {$urandom, $urandom};
        req_last[r]  = (qh[r] != qt[r]) ? ql[r][qh[r]%256] : 1'($urandom);
        rsp_ready[r] = ($urandom_range(0, 99) < rprob);
      end
      eng_ready        = ($urandom_range(0, 99) < rprob);
      eng_digest_valid = ($urandom_range(0, 99) < dprob);
      eng_digest       = {8{$urandom}};
      #1;
      x_rr = '0; x_rspv = '0; x_ev = 1'b0;
      if (m_ph == 1) begin
        x_ev = req_valid[m_own];
        x_rr[m_own] = eng_ready;
      end
      if (m_ph == 3) x_rspv[m_own] = 1'b1;
      chk("rnd req_ready", w_t'(req_ready), w_t'(x_rr));
      chk("rnd eng_valid", w_t'(eng_valid), w_t'(x_ev));
      if (x_ev) begin
        chk("rnd eng_data", w_t'(eng_data), w_t'(qd[m_own][qh[m_own]%256]));
        chk("rnd eng_last", w_t'(eng_last), w_t'(ql[m_own][qh[m_own]%256]));
      end
      chk("rnd eng_digest_ready", w_t'(eng_digest_ready), w_t'(m_ph == 2));
      chk("rnd rsp_valid", w_t'(rsp_valid), w_t'(x_rspv));
      chk("rnd busy", w_t'(busy), w_t'(m_ph != 0));
      chk("rnd owner", w_t'(owner), w_t'(m_own));
      chk("rnd done_cnt", w_t'(done_cnt), w_t'(m_done));
      chk("rnd rsp_digest", rsp_digest, m_dig);
      case (m_ph)
        0: if (|req_valid) begin
          k = m_rr;
          while (!req_valid[k]) k = (k + 1) % N;
          m_own = k; m_ph = 1;
        end
        1: if (req_valid[m_own] && eng_ready) begin
          if (ql[m_own][qh[m_own]%256]) m_ph = 2;
          qh[m_own]++;
        end
        2: if (eng_digest_valid) begin m_dig = eng_digest; m_ph = 3; end
        default: if (rsp_ready[m_own]) begin
          m_ph = 0; m_rr = (m_own + 1) % N; m_done++;
        end
      endcase
      @(negedge clk);
    end
  endtask

  int gown[8], gcyc[8], rcyc[8];
  int ng, nr;

  initial begin
    // rv rl d0 erdy edv rspr | x_rr x_ev x_ed x_el x_edr x_rspv x_busy x_own x_done x_dsel
    tbl[0]  = '{4'b0001, 4'b0000, 64'd0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 64'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0, 1'b0};
    tbl[1]  = '{4'b0101, 4'b0000, 64'd0, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 64'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0, 1'b0};
    tbl[2]  = '{4'b0101, 4'b0000, 64'd1, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 64'd1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0000, 64'd2, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 64'd2, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0, 1'b0};
    tbl[4]  = '{4'b0100, 4'b0000, 64'd2, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 64'd2, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0, 1'b0};
    tbl[5]  = '{4'b0100, 4'b0000, 64'd2, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 64'd2, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0, 1'b0};
    tbl[6]  = '{4'b0101, 4'b0000, 64'd2, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 64'd2, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0, 1'b0};
    tbl[7]  = '{4'b0101, 4'b0000, 64'd2, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b1, 64'd2, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0, 1'b0};
    tbl[8]  = '{4'b0101, 4'b0001, 64'd3, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b1, 64'd3, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0, 1'b0};
    tbl[9]  = '{4'b0100, 4'b0000, 64'd0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 64'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 32'd0, 1'b0};
    tbl[10] = '{4'b0100, 4'b0000, 64'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 32'd0, 1'b0};
    tbl[11] = '{4'b0100, 4'b0000, 64'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 64'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 32'd0, 1'b1};
    tbl[12] = '{4'b0100, 4'b0000, 64'd0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 64'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 32'd0, 1'b1};
    tbl[13] = '{4'b0100, 4'b0000, 64'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 64'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd1, 1'b1};
    tbl[14] = '{4'b0100, 4'b0000, 64'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, DEAD,  1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 32'd1, 1'b1};

    drive_idle();
    do_reset();
    req_data[2] = DEAD;
    for (int i = 0; i < 15; i++) begin
      req_valid = tbl[i].rv; req_last = tbl[i].rl; req_data[0] = tbl[i].d0;
      eng_ready = tbl[i].erdy; eng_digest_valid = tbl[i].edv; rsp_ready = tbl[i].rspr;
      eng_digest = (i == 10) ? D1 : ~D1;
      #1;
      chk($sformatf("t%0d req_ready", i), w_t'(req_ready), w_t'(tbl[i].x_rr));
      chk($sformatf("t%0d eng_valid", i), w_t'(eng_valid), w_t'(tbl[i].x_ev));
      if (tbl[i].x_ev) begin
        chk($sformatf("t%0d eng_data", i), w_t'(eng_data), w_t'(tbl[i].x_ed));
        chk($sformatf("t%0d eng_last", i), w_t'(eng_last), w_t'(tbl[i].x_el));
      end
      chk($sformatf("t%0d eng_digest_ready", i), w_t'(eng_digest_ready), w_t'(tbl[i].x_edr));
      chk($sformatf("t%0d rsp_valid", i), w_t'(rsp_valid), w_t'(tbl[i].x_rspv));
      chk($sformatf("t%0d busy", i), w_t'(busy), w_t'(tbl[i].x_busy));
      chk($sformatf("t%0d owner", i), w_t'(owner), w_t'(tbl[i].x_own));
      chk($sformatf("t%0d done_cnt", i), w_t'(done_cnt), w_t'(tbl[i].x_done));
      chk($sformatf("t%0d rsp_digest", i), rsp_digest, tbl[i].x_dsel ? D1 : '0);
      @(negedge clk);
    end

    // req2 owns the engine, rr_ptr is 1; reset lands on its second accepted beat.
    req_valid = 4'b0100; req_last = '0; eng_ready = 1'b1; eng_digest_valid = 1'b0;
    #1 chk("rst beat1 eng_valid", w_t'(eng_valid), w_t'(1'b1));
    @(negedge clk);
    #1 chk("rst beat2 req_ready", w_t'(req_ready), w_t'(4'b0100));
    rst_n = 1'b0;
    #1;
    chk("rst req_ready", w_t'(req_ready), w_t'(0));
    chk("rst eng_valid", w_t'(eng_valid), w_t'(0));
    chk("rst eng_digest_ready", w_t'(eng_digest_ready), w_t'(0));
    chk("rst rsp_valid", w_t'(rsp_valid), w_t'(0));
    chk("rst busy", w_t'(busy), w_t'(0));
    chk("rst owner", w_t'(owner), w_t'(0));
    chk("rst done_cnt", w_t'(done_cnt), w_t'(0));
    chk("rst rsp_digest", rsp_digest, w_t'(0));
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b1111; eng_ready = 1'b0;
    #1 chk("post-rst idle busy", w_t'(busy), w_t'(0));
    @(negedge clk);
    #1 chk("post-rst grant owner", w_t'(owner), w_t'(0));
    chk("post-rst grant busy", w_t'(busy), w_t'(1));

    // All four requesters with single-beat messages, everything always ready.
    do_reset();
    ng = 0; nr = 0;
    for (int c = 0; c < 24; c++) begin
      req_valid = 4'b1111; req_last = 4'b1111; eng_ready = 1'b1;
      eng_digest_valid = 1'b1; eng_digest = {8{$urandom}}; rsp_ready = 4'b1111;
      #1;
      if (eng_valid && eng_ready && ng < 8) begin gown[ng] = owner; gcyc[ng] = c; ng++; end
      if (|(rsp_valid & rsp_ready) && nr < 8) begin rcyc[nr] = c; nr++; end
      @(negedge clk);
    end
    chk("rr enough grants", w_t'(ng >= 5), w_t'(1));
    if (ng > 0) chk("rr first grant cycle", w_t'(gcyc[0]), w_t'(1));
    for (int k = 0; k < 5 && k < ng; k++) begin
      chk($sformatf("rr grant %0d owner", k), w_t'(gown[k]), w_t'(k % N));
      if (k > 0 && k - 1 < nr)
        chk($sformatf("rr gap %0d", k), w_t'(gcyc[k] - rcyc[k-1]), w_t'(2));
    end
    #1 chk("rr done_cnt", w_t'(done_cnt), w_t'(6));

    // Random mixed traffic, then req3-only single-beat messages back to back.
    do_reset();
    model_init();
    run_rand(1500, 4'b1111, 4, 30, 75, 70, 30);
    do_reset();
    model_init();
    run_rand(300, 4'b1000, 1, 100, 100, 100, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
